// File: rtl/pc_sequencer_pkg.sv
// Project-wide address and thread constants shared by the fetch front end.
package pc_sequencer_pkg;

  localparam int IMEM_ADDR_W     = 10;
  localparam int DMEM_ADDR_W     = 12;

  localparam int PC_WIDTH_DEF    = IMEM_ADDR_W;
  localparam int NUM_THREADS_DEF = 4;
  localparam int TID_WIDTH_DEF   = 2;
  localparam int START_ADDR_DEF  = 0;

  // Thread-id width an integrator should pick for a given thread count.
  function automatic int tid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_sequencer_rr_arbiter.sv
// Round-robin selector: grants the first requester after the last grant,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import pc_sequencer_pkg::*;
#(
  parameter int NUM_REQ   = NUM_THREADS_DEF,
  parameter int TID_WIDTH = TID_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [TID_WIDTH-1:0] last,
  output logic [TID_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  int best;
  int off;

  // Pick the requester with the smallest rotated distance from last+1.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    best        = NUM_REQ;
    off         = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        off = (j + NUM_REQ - 1 - int'(last)) % NUM_REQ;
        if (off < best) begin
          best        = off;
          grant       = TID_WIDTH'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multithreaded fetch PC sequencer: one PC per thread, round-robin issue,
// per-thread redirect that overrides the post-issue increment.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int TID_WIDTH   = TID_WIDTH_DEF,
  parameter int START_ADDR  = START_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   br_valid,
  input  logic [TID_WIDTH-1:0]   br_thread,
  input  logic [PC_WIDTH-1:0]    br_target,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [TID_WIDTH-1:0]   pc_tid,
  output logic                   pc_valid
);

  localparam logic [PC_WIDTH-1:0]  RST_PC   = PC_WIDTH'(START_ADDR);
  localparam logic [TID_WIDTH-1:0] RST_LAST = TID_WIDTH'(NUM_THREADS - 1);

  // Sequential increment; all-ones rolls over to zero.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

  logic [PC_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [TID_WIDTH-1:0] last_tid;
  logic [TID_WIDTH-1:0] grant;
  logic                 grant_valid;
  logic                 issue;
  logic                 br_hit;
  logic [PC_WIDTH-1:0]  sel_pc;

  rr_arbiter #(
    .NUM_REQ   (NUM_THREADS),
    .TID_WIDTH (TID_WIDTH)
  ) u_rr_arbiter (
    .req         (thread_en),
    .last        (last_tid),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Issue qualification, redirect range check and selected-PC mux.
  always_comb begin
    issue  = en & grant_valid;
    br_hit = br_valid && (int'(br_thread) < NUM_THREADS);
    sel_pc = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant == TID_WIDTH'(i)) sel_pc = pc_q[i];
    end
  end

  // Per-thread PCs: redirect has priority over the issue increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RST_PC;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (br_hit && (br_thread == TID_WIDTH'(i))) begin
          pc_q[i] <= br_target;
        end else if (issue && (grant == TID_WIDTH'(i))) begin
          pc_q[i] <= pc_inc(pc_q[i]);
        end
      end
    end
  end

  // Registered issue outputs and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out   <= RST_PC;
      pc_tid   <= '0;
      pc_valid <= 1'b0;
      last_tid <= RST_LAST;
    end else begin
      pc_valid <= issue;
      if (issue) begin
        pc_out   <= sel_pc;
        pc_tid   <= grant;
        last_tid <= grant;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: four threads, 3-bit thread id so that
// out-of-range redirect thread numbers can be driven.
module tb_pc_sequencer;

  localparam int PW = 10;
  localparam int NT = 4;
  localparam int TW = 3;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tid;
    logic [PW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [NT-1:0] thread_en = '0;
  logic          br_valid = 1'b0;
  logic [TW-1:0] br_thread = '0;
  logic [PW-1:0] br_target = '0;
  logic [PW-1:0] pc_out;
  logic [TW-1:0] pc_tid;
  logic          pc_valid;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_sequencer #(
    .PC_WIDTH    (PW),
    .NUM_THREADS (NT),
    .TID_WIDTH   (TW),
    .START_ADDR  (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .thread_en (thread_en),
    .br_valid  (br_valid),
    .br_thread (br_thread),
    .br_target (br_target),
    .pc_out    (pc_out),
    .pc_tid    (pc_tid),
    .pc_valid  (pc_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input logic v, input int tid, input int pc);
    exp_t e;
    e.v   = v;
    e.tid = TW'(tid);
    e.pc  = PW'(pc);
    sb.push_back(e);
  endfunction

  task automatic drive(input logic e, input logic [NT-1:0] te, input logic bv,
                       input logic [TW-1:0] bt, input logic [PW-1:0] bg);
    @(negedge clk);
    en        = e;
    thread_en = te;
    br_valid  = bv;
    br_thread = bt;
    br_target = bg;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    en        = 1'b0;
    thread_en = '0;
    br_valid  = 1'b0;
    br_thread = '0;
    br_target = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got, e;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, 0, 0);
    got = {pc_valid, pc_tid, pc_out};
    e = sb.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
               got.v, got.tid, got.pc, e.v, e.tid, e.pc);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_all_threads();
    exp_t got, e;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      push_exp(1'b1, k % 4, k / 4);
      drive(1'b1, 4'b1111, 1'b0, '0, '0);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL all_threads[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 k, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  task automatic test_sparse();
    exp_t got, e;
    int   tids[6] = '{0, 2, 0, 2, 3, 1};
    int   pcs[6]  = '{0, 0, 1, 1, 0, 0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      push_exp(1'b1, tids[k], pcs[k]);
      drive(1'b1, (k < 4) ? 4'b0101 : 4'b1010, 1'b0, '0, '0);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL sparse[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 k, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  task automatic test_branch();
    exp_t got, e;
    int   tid, pc;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      tid = c % 4;
      pc  = (tid == 1 && c > 13) ? ('h1F0 + (c - 17) / 4) : (c / 4);
      push_exp(1'b1, tid, pc);
      drive(1'b1, 4'b1111, (c == 13), TW'(1), 10'h1F0);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL branch[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 c, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t got, e;
    int   pcs[4] = '{'h000, 'h3FF, 'h000, 'h001};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b1, 0, pcs[k]);
      drive(1'b1, 4'b0001, (k == 0), TW'(0), 10'h3FF);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 k, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  task automatic test_stall();
    exp_t got, e;
    int   ens[11]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int   tes[11]  = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 0, 15};
    int   vs[11]   = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    int   tids[11] = '{0, 1, 1, 1, 1, 2, 3, 0, 1, 1, 2};
    int   pcs[11]  = '{0, 0, 0, 0, 0, 0, 'h055, 1, 1, 1, 1};
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      push_exp(vs[k] != 0, tids[k], pcs[k]);
      drive(ens[k] != 0, NT'(tes[k]), (k == 3), TW'(3), 10'h055);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL stall[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 k, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t got, e;
    int   bts[6] = '{5, 7, 4, 0, 0, 0};
    int   tids[6] = '{0, 1, 2, 3, 0, 1};
    int   pcs[6]  = '{0, 0, 0, 0, 1, 1};
    apply_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 4'b1111, 1'b0, '0, '0);
    @(negedge clk);
    br_valid  = 1'b1;
    br_thread = TW'(1);
    br_target = 10'h2AA;
    #2;
    reset = 1'b0;
    #1;
    push_exp(1'b0, 0, 0);
    got = {pc_valid, pc_tid, pc_out};
    e = sb.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
               got.v, got.tid, got.pc, e.v, e.tid, e.pc);
    end
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    en       = 1'b0;
    reset    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_exp(1'b1, tids[k], pcs[k]);
      drive(1'b1, 4'b1111, (k < 3), TW'(bts[k]), 10'h2AA);
      got = {pc_valid, pc_tid, pc_out};
      e = sb.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL post_reset_bad_thread[%0d]: got v=%0b tid=%0d pc=%h, required v=%0b tid=%0d pc=%h",
                 k, got.v, got.tid, got.pc, e.v, e.tid, e.pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_threads();
    test_sparse();
    test_branch();
    test_wrap();
    test_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
